ps2_jump_receiver: RTL and testbench
====================================

PS2_JUMP_RECEIVER -- requirements
Module: ps2_jump_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, giving the consecutive identical synchronized samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000, giving the clk cycles (2 ms at 100 MHz) without a falling ps2_clk edge after which a partial frame is discarded.
REQ-003 SHALL have parameter JUMP_CODE, default 8'h29, giving the scan code (space) that drives jump.
REQ-004 SHALL have port clk, input, 1, 100 MHz system clock; the block uses one clock only.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ps2_clk, input, 1, raw PS/2 clock; receive only, never driven.
REQ-007 SHALL have port ps2_data, input, 1, raw PS/2 data; receive only, never driven.
REQ-008 SHALL have port scan_code, output, 8, last accepted non-prefix code, held until the next one.
REQ-009 SHALL have port code_valid, output, 1, one-cycle strobe when scan_code updates.
REQ-010 SHALL have port is_break, output, 1, F0 preceded the current scan_code; valid with code_valid, held.
REQ-011 SHALL have port is_extended, output, 1, E0 preceded the current scan_code; valid with code_valid, held.
REQ-012 SHALL have port parity_err, output, 1, one-cycle strobe on odd-parity failure.
REQ-013 SHALL have port frame_err, output, 1, one-cycle strobe on bad stop bit or timeout.
REQ-014 SHALL have port jump, output, 1, level: high while JUMP_CODE is held; feeds the VGA controller jump input.
REQ-015 SHALL have port jump_pulse, output, 1, one-cycle strobe on the jump 0->1 transition only.

Function
REQ-016 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; the filtered clock changes only after FILTER_LEN equal synchronized samples.
REQ-017 SHALL define a bit event as a filtered ps2_clk 1->0 transition and sample synchronized ps2_data in that cycle.
REQ-018 SHALL use FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on a bit event with data 0; on data 1 it stays IDLE with no error.
REQ-019 SHALL shift 8 data bits LSB-first in DATA, then go DATA->PARITY after the 8th bit, PARITY->STOP, and STOP->IDLE on the next bit event.
REQ-020 SHALL treat parity as odd: ones in data plus parity bit is odd; on failure, parity_err strobes at STOP and the byte is dropped.
REQ-021 SHALL, on a stop bit of 0, strobe frame_err and drop the byte.
REQ-022 SHALL, when TIMEOUT_CYCLES elapse outside IDLE with no bit event, return to IDLE, strobe frame_err and clear the shift register; the counter clears on every bit event.
REQ-023 SHALL treat a good byte of 8'hF0 as setting break_pending and 8'hE0 as setting ext_pending, with no code_valid for either.
REQ-024 SHALL treat any other good byte as updating scan_code, is_break=break_pending, is_extended=ext_pending, strobing code_valid, then clearing both pending flags in the same cycle.
REQ-025 SHALL assert code_valid, parity_err or frame_err exactly 1 clk after the stop-bit event cycle.
REQ-026 SHALL set jump when code_valid has code==JUMP_CODE, !is_extended, !is_break; clear it on the same with is_break=1; other codes leave jump unchanged.
REQ-027 SHALL strobe jump_pulse in the same cycle jump rises; typematic repeats while jump=1 produce no pulse.
REQ-028 SHALL leave prefix flags and jump unaffected by errored frames.

Reset
REQ-029 SHALL clear all outputs, FSM (to IDLE), shift register, counters, pending flags and filter state (filtered clock =1) asynchronously on reset, including mid-frame.

Structure
REQ-030 SHALL place prefix codes (E0, F0), FSM state encoding and the default JUMP_CODE in shared package ps2_pkg.
REQ-031 SHALL implement synchronizers, glitch filter and falling-edge detect in sub-module ps2_clk_filter.

Verification
REQ-032 SHALL cover: frame 0x29 (parity 0, stop 1) -> scan_code=29, code_valid 1 cycle, jump=1, jump_pulse 1 cycle.
REQ-033 SHALL cover: 0x29 repeated, then F0,29 -> second code_valid without jump_pulse; F0 gives no code_valid; final code_valid with is_break=1, jump=0.
REQ-034 SHALL cover: 0x29 with parity 1 -> parity_err 1 cycle, no code_valid, jump unchanged.
REQ-035 SHALL cover: 5 bits then idle TIMEOUT_CYCLES (bench sets 1000) -> frame_err 1 cycle; next frame 0x1C -> scan_code=1C.
REQ-036 SHALL cover: ps2_clk low glitch of FILTER_LEN-1 cycles -> no bit event; E0,29 -> is_extended=1, jump stays 0.
REQ-037 SHALL cover: reset asserted after 4 bits -> all outputs 0; next 0x29 frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix codes, FSM encoding and receiver defaults
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_JUMP_CODE = 8'h29;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  function automatic logic odd_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes PS/2 lines, deglitches ps2_clk and flags its falling edges
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_sync, dat_sync;
  logic [CW-1:0] cnt;
  logic flip;
  // cnt tracks how many consecutive samples already disagree with the filtered level
  assign flip = (clk_sync[1] != clk_filt) && (cnt == CW'(FILTER_LEN - 1));
  assign data_sync = dat_sync[1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      cnt <= (clk_sync[1] == clk_filt || flip) ? '0 : cnt + 1'b1;
      clk_filt <= flip ? clk_sync[1] : clk_filt;
      fall <= flip && clk_filt;
    end
  end
endmodule

// File: rtl/ps2_jump_receiver.sv
// ps2_jump_receiver: PS/2 keyboard frame receiver with scan-code decode and jump-key tracking
module ps2_jump_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] JUMP_CODE = PS2_JUMP_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic       jump,
  output logic       jump_pulse
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_e state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_n;
  logic par, par_n;
  logic [TW-1:0] to_cnt;
  logic clk_filt, data_s, fall;
  logic timed_out, good, perr, ferr, prefix, jump_n;
  logic brk_pend, ext_pend;
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .clk_filt(clk_filt),
    .data_sync(data_s),
    .fall(fall)
  );
  assign timed_out = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n = bit_cnt;
    par_n = par;
    good = 1'b0;
    perr = 1'b0;
    ferr = 1'b0;
    if (timed_out) begin
      state_n = IDLE;
      shift_n = '0;
      ferr = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          state_n = data_s ? IDLE : DATA;
          bit_n = '0;
        end
        DATA: begin
          shift_n = {data_s, shift[7:1]};
          bit_n = bit_cnt + 1'b1;
          state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n = data_s;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          ferr = !data_s;
          perr = data_s && !odd_ok(shift, par);
          good = data_s && odd_ok(shift, par);
        end
      endcase
    end
  end
  assign prefix = (shift == PS2_BREAK) || (shift == PS2_EXT);
  // jump only follows the plain (non-extended) jump key; its break code releases it
  assign jump_n = (good && !prefix && shift == JUMP_CODE && !ext_pend) ? !brk_pend : jump;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      to_cnt <= '0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      scan_code <= '0;
      code_valid <= 1'b0;
      is_break <= 1'b0;
      is_extended <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      jump <= 1'b0;
      jump_pulse <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_n;
      par <= par_n;
      to_cnt <= (state == IDLE || fall || timed_out) ? '0 : to_cnt + 1'b1;
      code_valid <= good && !prefix;
      parity_err <= perr;
      frame_err <= ferr;
      jump <= jump_n;
      jump_pulse <= jump_n && !jump;
      if (good && !prefix) begin
        scan_code <= shift;
        is_break <= brk_pend;
        is_extended <= ext_pend;
      end
      brk_pend <= good ? (shift == PS2_BREAK || (brk_pend && shift == PS2_EXT)) : brk_pend;
      ext_pend <= good ? (shift == PS2_EXT || (ext_pend && shift == PS2_BREAK)) : ext_pend;
    end
  end
endmodule

// File: tb/tb_ps2_jump_receiver.sv
// tb_ps2_jump_receiver: directed frame-level checks of the PS/2 jump receiver
module tb_ps2_jump_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic code_valid, is_break, is_extended, parity_err, frame_err, jump, jump_pulse;
  int tests = 0;
  int fails = 0;
  int cv_cnt = 0, pe_cnt = 0, fe_cnt = 0, jp_cnt = 0;
  int cv0, pe0, fe0, jp0;

  ps2_jump_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(1000), .JUMP_CODE(8'h29)) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .scan_code(scan_code),
    .code_valid(code_valid),
    .is_break(is_break),
    .is_extended(is_extended),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .jump(jump),
    .jump_pulse(jump_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (parity_err) pe_cnt++;
    if (frame_err) fe_cnt++;
    if (jump_pulse) jp_cnt++;
  end

  task automatic mark();
    cv0 = cv_cnt;
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    jp0 = jp_cnt;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string name, input int cv, input int pe, input int fe, input int jp);
    tests++;
    if ((cv_cnt - cv0) !== cv || (pe_cnt - pe0) !== pe || (fe_cnt - fe0) !== fe || (jp_cnt - jp0) !== jp) begin
      fails++;
      $display("FAIL %s strobe cycles cv/pe/fe/jp got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", name,
               cv_cnt - cv0, pe_cnt - pe0, fe_cnt - fe0, jp_cnt - jp0, cv, pe, fe, jp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] sc, input logic br, input logic ex, input logic jm);
    tests++;
    if ({scan_code, is_break, is_extended, jump} !== {sc, br, ex, jm}) begin
      fails++;
      $display("FAIL %s scan/brk/ext/jump got %h/%b/%b/%b exp %h/%b/%b/%b", name,
               scan_code, is_break, is_extended, jump, sc, br, ex, jm);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({scan_code, code_valid, is_break, is_extended, parity_err, frame_err, jump, jump_pulse} !== 15'h0) begin
      fails++;
      $display("FAIL %s outputs got %h/%b%b%b%b%b%b%b exp all zero", name, scan_code, code_valid,
               is_break, is_extended, parity_err, frame_err, jump, jump_pulse);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_jump_press();
    mark();
    send_frame(8'h29, 1'b0);
    check_counts("press_strobes", 1, 0, 0, 1);
    check_out("press_out", 8'h29, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_typematic_break();
    mark();
    send_frame(8'h29, 1'b0);
    check_counts("repeat_strobes", 1, 0, 0, 0);
    check_out("repeat_out", 8'h29, 1'b0, 1'b0, 1'b1);
    mark();
    send_frame(8'hF0, 1'b0);
    check_counts("break_prefix_strobes", 0, 0, 0, 0);
    check_out("break_prefix_out", 8'h29, 1'b0, 1'b0, 1'b1);
    mark();
    send_frame(8'h29, 1'b0);
    check_counts("release_strobes", 1, 0, 0, 0);
    check_out("release_out", 8'h29, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_parity_error();
    mark();
    send_frame(8'h29, 1'b1);
    check_counts("parity_strobes", 0, 1, 0, 0);
    check_out("parity_out", 8'h29, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    check_counts("timeout_strobes", 0, 0, 1, 0);
    mark();
    send_frame(8'h1C, 1'b0);
    check_counts("after_timeout_strobes", 1, 0, 0, 0);
    check_out("after_timeout_out", 8'h1C, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch_extended();
    mark();
    ps2_data = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (7) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    ps2_data = 1'b1;
    send_frame(8'hE0, 1'b0);
    check_counts("ext_prefix_strobes", 0, 0, 0, 0);
    send_frame(8'h29, 1'b0);
    check_counts("ext_code_strobes", 1, 0, 0, 0);
    check_out("ext_code_out", 8'h29, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h29, 1'b0);
    check_out("pre_reset_out", 8'h29, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("midframe_reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    mark();
    send_frame(8'h29, 1'b0);
    check_counts("post_reset_strobes", 1, 0, 0, 1);
    check_out("post_reset_out", 8'h29, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_jump_press();
    test_typematic_break();
    test_parity_error();
    test_timeout();
    test_glitch_extended();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
